// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster pixel stream to 3x3 window generator (optional WINGEN_EOF_EN adds o_frame_done)
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    input  logic        i_sof,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
`ifdef WINGEN_EOF_EN
    output logic        o_frame_done,
`endif
    output logic        o_busy
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [23:0]   top_q, top_d;
    logic [23:0]   mid_q, mid_d;
    logic [23:0]   bot_q, bot_d;
    logic [71:0]   win_q, win_d;
    logic          valid_q, valid_d;

    logic [7:0]    line0_q [IMG_WIDTH];
    logic [7:0]    line1_q [IMG_WIDTH];

    logic          sof_acc;
    logic          accept;
    logic          emit;
    logic          col_last;
    logic          row_last;
    logic [CW-1:0] eff_col;
    logic [RW-1:0] eff_row;
    logic [7:0]    line0_rd;
    logic [7:0]    line1_rd;

    // A start-of-frame pixel always counts as (0,0), whatever the counters hold.
    always_comb begin
        sof_acc  = i_pixel_data_valid && i_sof;
        accept   = i_pixel_data_valid && (i_sof || (state_q != ST_IDLE));
        eff_col  = sof_acc ? '0 : col_q;
        eff_row  = sof_acc ? '0 : row_q;
        col_last = (eff_col == COL_LAST);
        row_last = (eff_row == ROW_LAST);
        emit     = accept && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
        line0_rd = line0_q[eff_col];
        line1_rd = line1_q[eff_col];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sof_acc) begin
                state_d = ST_FILL;
            end else begin
                case (state_q)
                    ST_FILL: if ((eff_row == ROW_ONE) && col_last) state_d = ST_RUN;
                    ST_RUN:  if (row_last && col_last) state_d = ST_IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : (eff_row + ROW_ONE);
            end else begin
                col_d = eff_col + COL_ONE;
                row_d = eff_row;
            end
        end
    end

    // The window keeps shifting across row boundaries; emit gating hides the straddling columns.
    always_comb begin
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        win_d   = win_q;
        valid_d = 1'b0;
        if (accept) begin
            top_d = {top_q[15:0], line1_rd};
            mid_d = {mid_q[15:0], line0_rd};
            bot_d = {bot_q[15:0], i_pixel_data};
        end
        if (emit) begin
            win_d   = {top_d, mid_d, bot_d};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            win_q   <= win_d;
            valid_q <= valid_d;
        end
    end

    // Line memories are read-before-write at the same column and are not reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            line1_q[eff_col] <= line0_rd;
            line0_q[eff_col] <= i_pixel_data;
        end
    end

`ifdef WINGEN_EOF_EN
    logic done_q, done_d;

    always_comb begin
        done_d = accept && !sof_acc && row_last && col_last;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign o_frame_done = done_q;
`endif

    assign o_pixel_data       = win_q;
    assign o_pixel_data_valid = valid_q;
    assign o_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - directed table-driven bench for window_gen_3x3 on a 4x4 frame
module tb_window_gen_3x3;

    logic        clk;
    logic        rst;
    logic [7:0]  pix;
    logic        pix_valid;
    logic        sof;
    logic [71:0] win;
    logic        win_valid;
    logic        busy;
`ifdef WINGEN_EOF_EN
    logic        frame_done;
`endif

    window_gen_3x3 #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .i_sof              (sof),
        .o_pixel_data       (win),
        .o_pixel_data_valid (win_valid),
`ifdef WINGEN_EOF_EN
        .o_frame_done       (frame_done),
`endif
        .o_busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  base;
        logic [71:0] win;
        logic        eof;
    } vec_t;

    vec_t vecs [8];
    vec_t exp_q [$];

    int   checks   = 0;
    int   failures = 0;
    logic drv_emit = 1'b0;
    logic exp_next = 1'b0;

    task automatic check72(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_next = 1'b0;
        end else begin
            if (win_valid || exp_next) begin
                check1("valid_timing", win_valid, exp_next);
                if (exp_q.size() == 0) begin
                    check_int("window_expected_count", 1, 0);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    if (win_valid) check72("window_data", win, e.win);
`ifdef WINGEN_EOF_EN
                    if (win_valid) check1("frame_done_with_window", frame_done, e.eof);
`endif
                end
            end
`ifdef WINGEN_EOF_EN
            if (frame_done && !win_valid) check1("frame_done_without_valid", frame_done, 1'b0);
`endif
            exp_next = drv_emit;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pix_valid = 1'b0;
            sof       = 1'b0;
            drv_emit  = 1'b0;
            pix       = 8'($urandom);
        end
    endtask

    task automatic send_px(input logic [7:0] p, input logic s, input logic e);
        @(posedge clk);
        #1;
        pix_valid = 1'b1;
        pix       = p;
        sof       = s;
        drv_emit  = e;
    endtask

    task automatic send_frame(input logic [7:0] base, input int gap_max, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            int r;
            int c;
            r = idx / 4;
            c = idx % 4;
            if (gap_max > 0) idle($urandom_range(0, gap_max));
            send_px(base + 8'(r * 16 + c), idx == 0, (r >= 2) && (c >= 2));
        end
    endtask

    task automatic load_exp(input logic [7:0] base, input int n);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].base == base && k < n) begin
                exp_q.push_back(vecs[i]);
                k++;
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 72'h000102_101112_202122, 1'b0};
        vecs[1] = '{8'h00, 72'h010203_111213_212223, 1'b0};
        vecs[2] = '{8'h00, 72'h101112_202122_303132, 1'b0};
        vecs[3] = '{8'h00, 72'h111213_212223_313233, 1'b1};
        vecs[4] = '{8'h80, 72'h808182_909192_A0A1A2, 1'b0};
        vecs[5] = '{8'h80, 72'h818283_919293_A1A2A3, 1'b0};
        vecs[6] = '{8'h80, 72'h909192_A0A1A2_B0B1B2, 1'b0};
        vecs[7] = '{8'h80, 72'h919293_A1A2A3_B1B2B3, 1'b1};

        rst       = 1'b1;
        pix       = 8'h00;
        pix_valid = 1'b0;
        sof       = 1'b0;
        idle(3);
        check72("reset_window", win, 72'h0);
        check1("reset_valid", win_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
`ifdef WINGEN_EOF_EN
        check1("reset_frame_done", frame_done, 1'b0);
`endif
        rst = 1'b0;
        idle(2);

        // Pixels without a start of frame are ignored.
        for (int i = 0; i < 6; i++) send_px(8'h40 + 8'(i), 1'b0, 1'b0);
        idle(2);
        check1("no_sof_busy", busy, 1'b0);

        // Continuous frame.
        load_exp(8'h00, 4);
        send_frame(8'h00, 0, 16);
        idle(3);
        check_int("cont_windows_left", exp_q.size(), 0);
        check1("cont_busy_after", busy, 1'b0);
        check72("cont_window_held", win, 72'h111213_212223_313233);

        // Same frame with random gaps.
        load_exp(8'h00, 4);
        send_frame(8'h00, 5, 16);
        idle(3);
        check_int("gap_windows_left", exp_q.size(), 0);

        // Abort frame A at (2,1) with a new start of frame B.
        send_frame(8'h00, 0, 9);
        load_exp(8'h80, 4);
        send_frame(8'h80, 0, 16);
        idle(3);
        check_int("abort_windows_left", exp_q.size(), 0);

        // Reset pulsed mid-frame.
        load_exp(8'h00, 2);
        send_frame(8'h00, 0, 12);
        idle(1);
        check1("run_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pix_valid = 1'b0;
        #1;
        check72("midreset_window", win, 72'h0);
        check1("midreset_valid", win_valid, 1'b0);
        check1("midreset_busy", busy, 1'b0);
        idle(2);
        rst = 1'b0;
        idle(1);
        check_int("midreset_windows_left", exp_q.size(), 0);
        load_exp(8'h00, 4);
        send_frame(8'h00, 0, 16);
        idle(3);
        check_int("post_reset_windows_left", exp_q.size(), 0);
        check1("post_reset_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
